battle_turn_sequencer: RTL and testbench
========================================

// Module: battle_turn_sequencer
// PURPOSE
//  Top-level turn scheduler for the battle screen. Drives the 4-bit state bus that the
//  phase blocks (menu, player attack bar, enemy dodge box) decode. Collects their
//  finished handshakes and HP levels to sequence MENU -> ATTACK -> DODGE -> MENU,
//  ending in WIN/LOSE. All state-bus changes are frame-aligned, so no phase sees a
//  mid-frame change.
// PARAMETERS
//  TIMEOUT_FRAMES  1800  frames allowed in ATTACK or DODGE before the watchdog forces exit (30 s @60 Hz)
//  TURN_W          8     width of turn counter
// PORTS
//  clk                input   1       pixel clock
//  rst                input   1       synchronous, active-high reset
//  hcount_in          input   11      raster x; frame tick = (hcount_in==0 && vcount_in==0)
//  vcount_in          input   10      raster y
//  start_in           input   1       1-cycle pulse: begin/restart game
//  menu_valid_in      input   1       1-cycle pulse: menu selection made
//  menu_choice_in     input   2       0=FIGHT, 1..3=ACT/ITEM/MERCY
//  attack_finished_in input   1       level from attack phase, held while bus==ATTACK
//  dodge_finished_in  input   1       level from dodge phase, held while bus==DODGE
//  enemy_hp_in        input   11      remaining enemy HP (0 = dead)
//  soul_hp_in         input   8       remaining player HP (0 = dead)
//  state_out          output  4       battle state bus (codes in battle_pkg)
//  turn_count_out     output  TURN_W  completed turns, saturating
//  game_over_out      output  1       high in WIN or LOSE
//  timeout_err_out    output  1       sticky: watchdog fired since last start
// BEHAVIOUR
//  Reset: state_out=IDLE, turn_count_out=0, game_over_out=0, timeout_err_out=0;
//   pending flag, frame counter and watchdog cleared.
//  Codes: IDLE=0000 ATTACK=0001 MENU=0010 DODGE=0011 WIN=0100 LOSE=0101.
//  Two-stage update: a decision sets next_state and the pending flag. state_out loads
//   next_state in the cycle after the next frame tick, i.e. the first cycle of the following frame.
//   A decision made on the tick cycle itself waits for the next tick. Pending is held
//   until applied; later decisions in the same frame are ignored (first wins).
//  Phase entry: on every state_out change, the frame counter is cleared and the
//   finished/HP evaluation is masked until one frame tick has passed. This guards
//   against stale finished levels.
//  IDLE:   start_in -> MENU.
//  MENU:   menu_valid_in & choice==0 -> ATTACK; choice!=0 -> DODGE. A menu_valid_in
//          while pending is already set is dropped.
//  ATTACK: attack_finished_in -> WIN if enemy_hp_in==0, else DODGE.
//  DODGE:  soul_hp_in==0 (checked every cycle after the mask, priority over finished)
//          -> LOSE. Otherwise dodge_finished_in -> MENU and turn_count+1 (saturates at
//          2^TURN_W-1); the increment occurs when state_out changes.
//  Watchdog: frame counter counts ticks in ATTACK/DODGE. Reaching TIMEOUT_FRAMES sets
//   timeout_err_out and acts exactly as the finished input of that phase (HP rules apply).
//  WIN/LOSE: terminal, game_over_out=1. start_in -> MENU, with turn_count and
//   timeout_err cleared when the MENU takes effect.
//  start_in in MENU/ATTACK/DODGE is ignored.
//  ATTACK is always separated from a prior ATTACK by MENU, so the attack block sees a
//   fresh edge into 0001.
//  Reset mid-phase returns to IDLE in one cycle; pending decision discarded.
// STRUCTURE
//  battle_pkg: typedef enum logic[3:0] battle_state_t (codes above); MENU_FIGHT=2'd0;
//   shared with the phase blocks.
//  Sub-module phase_watchdog: frame-tick counter with clear, enable and a
//   TIMEOUT_FRAMES compare. Output expire_out is a 1-cycle pulse.
//  Top level: FSM + pending register + turn counter.
// TESTING
//  1 rst, start_in at hcount=5/vcount=0 -> state_out=MENU in cycle after next (0,0) tick.
//  2 MENU, valid choice=0 -> ATTACK next frame. finished=1, enemy_hp=40 -> DODGE.
//    dodge_finished=1, soul_hp=20 -> MENU, turn_count=1.
//  3 ATTACK, enemy_hp=0, finished=1 -> WIN, game_over=1. start_in -> MENU, turn_count=0.
//  4 DODGE, soul_hp=0 and dodge_finished=1 same cycle -> LOSE (HP priority).
//  5 TIMEOUT_FRAMES=4, ATTACK, no finished -> after 4 ticks timeout_err=1, state DODGE.
//  6 finished held high on ATTACK entry frame -> no exit until after first tick.
//    rst mid-DODGE -> IDLE next cycle.

Source files
------------

// File: rtl/battle_pkg.sv
// battle_pkg: battle state codes and menu constants shared by the turn sequencer and phase blocks
package battle_pkg;
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0000,
        ST_ATTACK = 4'b0001,
        ST_MENU   = 4'b0010,
        ST_DODGE  = 4'b0011,
        ST_WIN    = 4'b0100,
        ST_LOSE   = 4'b0101
    } battle_state_t;
    localparam logic [1:0] MENU_FIGHT = 2'd0;
endpackage

// File: rtl/phase_watchdog.sv
// phase_watchdog: counts frame ticks while enabled and pulses once when the limit is reached
module phase_watchdog #(
    parameter int TIMEOUT_FRAMES = 1800
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    input  logic clear_in,
    input  logic enable_in,
    output logic expire_out
);
    localparam int CW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_FRAMES);
    logic [CW-1:0] count;
    logic advance;
    assign advance = enable_in && tick_in && count != LIMIT;
    // Count up to the limit and hold there so the expiry is a single-cycle pulse
    always_ff @(posedge clk) begin
        if (rst || clear_in) begin
            count      <= '0;
            expire_out <= 1'b0;
        end else begin
            count      <= advance ? count + 1'b1 : count;
            expire_out <= advance && count == LIMIT - 1'b1;
        end
    end
endmodule

// File: rtl/battle_turn_sequencer.sv
// battle_turn_sequencer: frame-aligned MENU/ATTACK/DODGE turn scheduler driving the battle state bus
module battle_turn_sequencer
    import battle_pkg::*;
#(
    parameter int TIMEOUT_FRAMES = 1800,
    parameter int TURN_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              start_in,
    input  logic              menu_valid_in,
    input  logic [1:0]        menu_choice_in,
    input  logic              attack_finished_in,
    input  logic              dodge_finished_in,
    input  logic [10:0]       enemy_hp_in,
    input  logic [7:0]        soul_hp_in,
    output logic [3:0]        state_out,
    output logic [TURN_W-1:0] turn_count_out,
    output logic              game_over_out,
    output logic              timeout_err_out
);
    battle_state_t state, next_state, decision;
    logic pending, masked, decide, expire, tick, apply, in_phase, restart;
    logic [TURN_W-1:0] turn_count;
    assign tick     = hcount_in == 11'd0 && vcount_in == 10'd0;
    assign apply    = pending && tick;
    assign in_phase = state == ST_ATTACK || state == ST_DODGE;
    assign restart  = state == ST_IDLE || state == ST_WIN || state == ST_LOSE;
    assign state_out      = state;
    assign turn_count_out = turn_count;
    assign game_over_out  = state == ST_WIN || state == ST_LOSE;
    phase_watchdog #(
        .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick),
        .clear_in  (apply),
        .enable_in (in_phase),
        .expire_out(expire)
    );
    // Pick the candidate next state; finished/HP inputs are ignored until the entry mask lifts
    always_comb begin
        decide   = 1'b0;
        decision = state;
        case (state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                decide   = start_in;
                decision = ST_MENU;
            end
            ST_MENU: begin
                decide   = menu_valid_in;
                decision = menu_choice_in == MENU_FIGHT ? ST_ATTACK : ST_DODGE;
            end
            ST_ATTACK: begin
                decide   = !masked && (attack_finished_in || expire);
                decision = enemy_hp_in == 11'd0 ? ST_WIN : ST_DODGE;
            end
            ST_DODGE: begin
                decide   = !masked && (soul_hp_in == 8'd0 || dodge_finished_in || expire);
                decision = soul_hp_in == 8'd0 ? ST_LOSE : ST_MENU;
            end
            default: decide = 1'b0;
        endcase
    end
    // Latch the first decision of a frame and apply it on the next frame tick with turn/timeout bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            next_state      <= ST_IDLE;
            pending         <= 1'b0;
            masked          <= 1'b0;
            turn_count      <= '0;
            timeout_err_out <= 1'b0;
        end else if (apply) begin
            state   <= next_state;
            pending <= 1'b0;
            masked  <= 1'b1;
            if (next_state == ST_MENU && restart) begin
                turn_count      <= '0;
                timeout_err_out <= 1'b0;
            end else if (next_state == ST_MENU && turn_count != '1) begin
                turn_count <= turn_count + 1'b1;
            end
        end else begin
            if (tick) masked <= 1'b0;
            if (decide && !pending) begin
                pending    <= 1'b1;
                next_state <= decision;
            end
            if (expire) timeout_err_out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_battle_turn_sequencer.sv
// tb_battle_turn_sequencer: directed and randomized checks against a frame-level behavioural model
module tb_battle_turn_sequencer;
    localparam int TO = 4;
    localparam int HN = 8;
    localparam int VN = 3;
    localparam int C_IDLE = 0, C_ATTACK = 1, C_MENU = 2, C_DODGE = 3, C_WIN = 4, C_LOSE = 5;
    logic clk = 1'b0, rst = 1'b1;
    logic start_in = 1'b0, menu_valid_in = 1'b0, attack_finished_in = 1'b0, dodge_finished_in = 1'b0;
    logic [10:0] hcount_in = 11'd0;
    logic [9:0]  vcount_in = 10'd0;
    logic [1:0]  menu_choice_in = 2'd0;
    logic [10:0] enemy_hp_in = 11'd40;
    logic [7:0]  soul_hp_in = 8'd20;
    logic [3:0]  state_out;
    logic [7:0]  turn_count_out;
    logic        game_over_out, timeout_err_out;
    int n_tests = 0, n_fail = 0;
    int m_state = C_IDLE, m_next = C_IDLE, m_ticks = 0, m_turn = 0;
    bit m_pend = 0, m_terr = 0, m_exp = 0;
    always #5 clk = ~clk;
    battle_turn_sequencer #(.TIMEOUT_FRAMES(TO), .TURN_W(8)) dut (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .start_in(start_in), .menu_valid_in(menu_valid_in), .menu_choice_in(menu_choice_in),
        .attack_finished_in(attack_finished_in), .dodge_finished_in(dodge_finished_in),
        .enemy_hp_in(enemy_hp_in), .soul_hp_in(soul_hp_in), .state_out(state_out),
        .turn_count_out(turn_count_out), .game_over_out(game_over_out), .timeout_err_out(timeout_err_out)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // Model: one decision per frame, applied at the frame tick; inputs judged only after one tick in the phase
    always @(posedge clk) begin
        bit tick, dv, fire, open;
        int ds;
        if (rst) begin
            m_state = C_IDLE; m_next = C_IDLE; m_pend = 0; m_ticks = 0; m_turn = 0; m_terr = 0; m_exp = 0;
        end else begin
            tick = hcount_in == 0 && vcount_in == 0;
            fire = m_exp;
            m_exp = 0;
            open = m_ticks >= 1;
            dv = 0;
            ds = m_state;
            if (m_state == C_IDLE || m_state == C_WIN || m_state == C_LOSE) begin
                dv = start_in; ds = C_MENU;
            end else if (m_state == C_MENU) begin
                dv = menu_valid_in; ds = (menu_choice_in == 0) ? C_ATTACK : C_DODGE;
            end else if (m_state == C_ATTACK) begin
                dv = open && (attack_finished_in || fire); ds = (enemy_hp_in == 0) ? C_WIN : C_DODGE;
            end else begin
                dv = open && (soul_hp_in == 0 || dodge_finished_in || fire); ds = (soul_hp_in == 0) ? C_LOSE : C_MENU;
            end
            if (fire) m_terr = 1;
            if (tick && m_pend) begin
                if (m_next == C_MENU && m_state == C_DODGE) m_turn = (m_turn < 255) ? m_turn + 1 : 255;
                else if (m_next == C_MENU) begin m_turn = 0; m_terr = 0; end
                m_state = m_next; m_pend = 0; m_ticks = 0;
            end else begin
                if (tick) begin
                    m_ticks++;
                    m_exp = (m_state == C_ATTACK || m_state == C_DODGE) && m_ticks == TO;
                end
                if (dv && !m_pend) begin m_pend = 1; m_next = ds; end
            end
        end
    end
    always @(negedge clk) begin
        check("state", state_out, m_state);
        check("turn", turn_count_out, m_turn);
        check("game_over", game_over_out, m_state == C_WIN || m_state == C_LOSE);
        check("timeout_err", timeout_err_out, m_terr);
    end
    task automatic step();
        @(posedge clk);
        #2;
        if (hcount_in == 11'(HN - 1)) begin
            hcount_in = 11'd0;
            vcount_in = (vcount_in == 10'(VN - 1)) ? 10'd0 : vcount_in + 10'd1;
        end else hcount_in = hcount_in + 11'd1;
    endtask
    task automatic to_tick();
        while (!(hcount_in == 0 && vcount_in == 0)) step();
        step();
    endtask
    task automatic pulse_start();
        start_in = 1'b1; step(); start_in = 1'b0;
    endtask
    task automatic pulse_menu(input logic [1:0] c);
        menu_choice_in = c; menu_valid_in = 1'b1; step(); menu_valid_in = 1'b0;
    endtask
    initial begin
        repeat (3) step();
        check("rst_state", state_out, 4'b0000);
        check("rst_turn", turn_count_out, 0);
        check("rst_game_over", game_over_out, 0);
        check("rst_timeout", timeout_err_out, 0);
        rst = 1'b0;
        while (!(hcount_in == 5 && vcount_in == 0)) step();
        pulse_start();
        check("start_waits_tick", state_out, 4'b0000);
        to_tick();
        check("start_menu", state_out, 4'b0010);
        pulse_menu(2'd0);
        pulse_menu(2'd1);
        to_tick();
        check("first_wins_attack", state_out, 4'b0001);
        enemy_hp_in = 11'd40; attack_finished_in = 1'b1;
        to_tick();
        check("entry_mask", state_out, 4'b0001);
        to_tick();
        check("attack_to_dodge", state_out, 4'b0011);
        attack_finished_in = 1'b0; soul_hp_in = 8'd20; dodge_finished_in = 1'b1;
        to_tick();
        check("dodge_masked", state_out, 4'b0011);
        to_tick();
        check("dodge_to_menu", state_out, 4'b0010);
        check("turn_one", turn_count_out, 1);
        dodge_finished_in = 1'b0;
        pulse_menu(2'd0);
        to_tick();
        enemy_hp_in = 11'd0; attack_finished_in = 1'b1;
        to_tick(); to_tick();
        check("win_state", state_out, 4'b0100);
        check("win_game_over", game_over_out, 1);
        attack_finished_in = 1'b0; enemy_hp_in = 11'd40;
        pulse_start();
        to_tick();
        check("restart_menu", state_out, 4'b0010);
        check("restart_turn", turn_count_out, 0);
        pulse_menu(2'd2);
        to_tick();
        check("act_to_dodge", state_out, 4'b0011);
        soul_hp_in = 8'd0; dodge_finished_in = 1'b1;
        to_tick(); to_tick();
        check("hp_priority_lose", state_out, 4'b0101);
        dodge_finished_in = 1'b0; soul_hp_in = 8'd20;
        pulse_start();
        to_tick();
        while (!(hcount_in == 0 && vcount_in == 0)) step();
        pulse_menu(2'd0);
        check("tick_decision_held", state_out, 4'b0010);
        to_tick();
        check("tick_decision_applied", state_out, 4'b0001);
        repeat (TO) to_tick();
        check("timeout_not_yet_exit", state_out, 4'b0001);
        step();
        check("timeout_err_set", timeout_err_out, 1);
        to_tick();
        check("timeout_to_dodge", state_out, 4'b0011);
        check("timeout_err_sticky", timeout_err_out, 1);
        rst = 1'b1;
        step();
        check("mid_rst_idle", state_out, 4'b0000);
        check("mid_rst_timeout", timeout_err_out, 0);
        rst = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            start_in = $urandom_range(0, 99) < 3;
            menu_valid_in = $urandom_range(0, 99) < 5;
            menu_choice_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 2) attack_finished_in = ~attack_finished_in;
            if ($urandom_range(0, 99) < 2) dodge_finished_in = ~dodge_finished_in;
            if (hcount_in == 0 && vcount_in == 0) begin
                enemy_hp_in = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'(1 + $urandom_range(0, 99));
                soul_hp_in = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'(1 + $urandom_range(0, 99));
            end
            rst = $urandom_range(0, 999) == 0;
            step();
        end
        rst = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
